lockreg_bank_ctrl: RTL
======================

LOCKREG_BANK_CTRL -- requirements
Module: lockreg_bank_ctrl

Interface
REQ-001 Parameter NREGS, 4, number of lockable registers in the bank (power of 2, 2..16).
REQ-002 Parameter W, 8, data width of each register.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1 each  write request from requester 0 / 1.
REQ-006 req0_addr / req1_addr  input  $clog2(NREGS) each  target register index.
REQ-007 req0_data / req1_data  input  W each  write data.
REQ-008 req0_lock / req1_lock  input  1 each  lock the target register after this write.
REQ-009 req0_ready / req1_ready  output  1 each  one-cycle acceptance pulse to the granted requester.
REQ-010 req0_err / req1_err  output  1 each  one-cycle pulse with ready; set when the write was rejected.
REQ-011 lock_all  input  1  level; while high, sets every lock bit on the next edge.
REQ-012 reg_q  output  NREGS*W  register contents; register i occupies bits [i*W +: W].
REQ-013 lock_q  output  NREGS  per-register sticky lock status.
REQ-014 busy  output  1  high while the FSM is not IDLE.

Function
REQ-015 FSM states: IDLE, ARB, WRITE, ACK; IDLE->ARB when any reqN_valid is high; ARB->WRITE always; WRITE->ACK always; ACK->IDLE always.
REQ-016 ARB: round-robin; when both requesters are valid, grant the one not granted last; a lone valid requester is granted regardless of history.
REQ-017 ARB: latch the granted requester's addr, data and lock into internal holding registers; later changes on request inputs are ignored.
REQ-018 WRITE: if lock_q[addr]==0, reg_q[addr] <= data; if lock_q[addr]==1, no register changes and the error flag is set.
REQ-019 WRITE: if latched lock==1 and the register was unlocked, lock_q[addr] <= 1 in the same cycle as the data write.
REQ-020 ACK: assert reqN_ready of the granted requester for exactly one cycle; assert reqN_err in the same cycle iff rejected.
REQ-021 Latency: valid seen in IDLE at edge k -> ready high during cycle k+3; throughput is one write per 4 cycles.
REQ-022 Requester holds valid until ready; valid dropped before ARB samples it is treated as withdrawn (FSM returns IDLE from ARB with no write and no ready).
REQ-023 Lock bits are sticky: never cleared except by reset; lock requests to an already-locked register are rejected with err.
REQ-024 lock_all high at an edge sets all lock_q bits; if that edge is the WRITE edge, lock_all takes priority and the write is rejected with err.
REQ-025 busy == (state != IDLE); ready/err are never high outside ACK.

Reset
REQ-026 rst_n low at a rising edge: state<=IDLE, reg_q<=0, lock_q<=0, ready/err<=0, round-robin pointer<=requester 0 last-granted (requester 1 wins first tie).
REQ-027 Reset mid-operation aborts the transaction with no ready pulse; reset has priority over all other inputs.

Structure
REQ-028 Shared package lockreg_pkg holds the FSM state enum (IDLE, ARB, WRITE, ACK) and default NREGS/W constants.
REQ-029 One sub-module rr_arb2 (2-way round-robin arbiter with last-grant pointer); storage and FSM stay in the top.

Verification
REQ-030 Reset, req0 writes 0xA5 to reg 2 -> ready0 at cycle +3, err0=0, reg_q[23:16]=0xA5, lock_q=0000.
REQ-031 req1 writes 0x3C to reg 1 with lock=1, then 0xFF to reg 1 -> first ok, lock_q=0010; second err1=1, reg 1 stays 0x3C.
REQ-032 req0 and req1 valid together, both held -> grants alternate 1,0,1,0 over four transactions.
REQ-033 lock_all pulsed for one cycle while idle -> lock_q=1111; any following write -> err, reg_q unchanged.
REQ-034 rst_n low during WRITE of 0x77 to reg 0 -> no ready, reg_q=0, lock_q=0, state IDLE the next cycle.
REQ-035 req0_valid high one cycle then dropped before ARB samples it -> no write, no ready, FSM returns IDLE.

Source files
------------

// File: rtl/lockreg_pkg.sv
// rtl/lockreg_pkg.sv - shared state encoding and default sizes for the lock register bank
package lockreg_pkg;

    localparam int NREGS_DEF = 4;
    localparam int W_DEF     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        WRITE = 2'd2,
        ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with a last-grant pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic last_gnt;

    // On a tie the requester not served last wins; a lone request wins outright.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = (req == 2'b11) ? ~last_gnt : req[1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_gnt <= 1'b0;
        else if (update && gnt_valid)
            last_gnt <= gnt_idx;
    end

endmodule

// File: rtl/lockreg_bank_ctrl.sv
// rtl/lockreg_bank_ctrl.sv - two-requester register bank with sticky per-register write locks
module lockreg_bank_ctrl
    import lockreg_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int W     = W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0_valid,
    input  logic [$clog2(NREGS)-1:0] req0_addr,
    input  logic [W-1:0]             req0_data,
    input  logic                     req0_lock,
    output logic                     req0_ready,
    output logic                     req0_err,
    input  logic                     req1_valid,
    input  logic [$clog2(NREGS)-1:0] req1_addr,
    input  logic [W-1:0]             req1_data,
    input  logic                     req1_lock,
    output logic                     req1_ready,
    output logic                     req1_err,
    input  logic                     lock_all,
    output logic [NREGS*W-1:0]       reg_q,
    output logic [NREGS-1:0]         lock_q,
    output logic                     busy
);

    localparam int AW = $clog2(NREGS);

    state_t         state;
    logic [AW-1:0]  hold_addr;
    logic [W-1:0]   hold_data;
    logic           hold_lock;
    logic           hold_idx;
    logic           gnt_valid;
    logic           gnt_idx;
    logic           reject;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({req1_valid, req0_valid}),
        .update    (state == ARB),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // lock_all on the write edge wins over the pending write
    assign reject = lock_all | lock_q[hold_addr];
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            reg_q      <= '0;
            lock_q     <= '0;
            hold_addr  <= '0;
            hold_data  <= '0;
            hold_lock  <= 1'b0;
            hold_idx   <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_err   <= 1'b0;
            req1_err   <= 1'b0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_err   <= 1'b0;
            req1_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid)
                        state <= ARB;
                end
                ARB: begin
                    if (gnt_valid) begin
                        hold_idx  <= gnt_idx;
                        hold_addr <= gnt_idx ? req1_addr : req0_addr;
                        hold_data <= gnt_idx ? req1_data : req0_data;
                        hold_lock <= gnt_idx ? req1_lock : req0_lock;
                        state     <= WRITE;
                    end else begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    if (!reject) begin
                        reg_q[hold_addr*W +: W] <= hold_data;
                        if (hold_lock)
                            lock_q[hold_addr] <= 1'b1;
                    end
                    // ready/err are registered here so they are high exactly during ACK
                    req0_ready <= ~hold_idx;
                    req1_ready <= hold_idx;
                    req0_err   <= ~hold_idx & reject;
                    req1_err   <= hold_idx & reject;
                    state      <= ACK;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (lock_all)
                lock_q <= '1;
        end
    end

endmodule
